lcd_controller: RTL

LCD_CONTROLLER -- requirements
Module: lcd_controller

---
 rtl/lcd_pkg.sv | 36 +++
 rtl/lcd_fifo.sv | 58 +++++
 rtl/lcd_controller.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 LCD controller.
// Holds the FSM state encoding, the power-on init command table and the
// opcodes that need the long post-pulse wait.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP = 3'd0,
        ST_INIT  = 3'd1,
        ST_IDLE  = 3'd2,
        ST_SETUP = 3'd3,
        ST_PULSE = 3'd4,
        ST_WAIT  = 3'd5
    } state_t;

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;
    localparam int         INIT_LEN  = 4;

    // Init sequence: 8-bit bus/2 lines, display on, clear, entry mode increment
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] cmd;
        case (idx)
            2'd0:    cmd = 8'h38;
            2'd1:    cmd = 8'h0C;
            2'd2:    cmd = 8'h01;
            default: cmd = 8'h06;
        endcase
        return cmd;
    endfunction

    // Clear and home are the only instructions that need the long wait
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
        return !rs && ((b == CMD_CLEAR) || (b == CMD_HOME));
    endfunction

endpackage

// File: rtl/lcd_fifo.sv
// Write buffer between the processor strobe and the LCD sequencer.
// Push is accepted only when not full (a push alongside a pop on a full
// buffer is dropped); the head entry is presented combinationally.
module lcd_fifo #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 9,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign full      = (r_count == (AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign rdata     = r_mem[r_rd_ptr];
    assign w_push_ok = push & ~full;
    assign w_pop_ok  = pop & ~empty;

    // Storage array; contents need no reset since the pointers define validity
    always_ff @(posedge clock) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks occupancy
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/lcd_controller.sv
// HD44780 8-bit write-only controller: power-up delay, init sequence, then
// drains a write buffer. Strobe-to-EN latency is 3 cycles from an empty buffer.
// Writes are buffered at any time; ready drops when the buffer is full or init pending.
module lcd_controller
    import lcd_pkg::*;
#(
    parameter int EN_CYC     = 25,
    parameter int CMD_WAIT   = 2500,
    parameter int CLR_WAIT   = 100000,
    parameter int PWRUP_WAIT = 750000,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        lcd_write,
    input  logic [31:0] lcd_data,
    output logic        ready,
    output logic        overflow,
    output logic [7:0]  LCD_DATA,
    output logic        LCD_RS,
    output logic        LCD_RW,
    output logic        LCD_EN,
    output logic        LCD_ON
);

    localparam int AW = $clog2(FIFO_DEPTH);

    state_t      r_state;
    logic [19:0] r_cnt;
    logic [1:0]  r_init_idx;
    logic        r_init_done;
    logic [7:0]  r_data;
    logic        r_rs;
    logic        r_en;
    logic        r_overflow;

    logic [8:0]  w_head;
    logic        w_full;
    logic        w_empty;
    logic [AW:0] w_count;
    logic        w_pop;
    logic [19:0] w_wait_load;
    logic        w_unused_bits;

    assign w_pop         = (r_state == ST_IDLE) & ~w_empty;
    assign w_wait_load   = is_long_cmd(r_rs, r_data) ? 20'(CLR_WAIT - 1) : 20'(CMD_WAIT - 1);
    assign w_unused_bits = &{1'b0, lcd_data[31:9], w_count};

    assign ready    = r_init_done & ~w_full;
    assign overflow = r_overflow;
    assign LCD_DATA = r_data;
    assign LCD_RS   = r_rs;
    assign LCD_RW   = 1'b0;
    assign LCD_EN   = r_en;
    assign LCD_ON   = 1'b1;

    lcd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (9)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (lcd_write),
        .wdata (lcd_data[8:0]),
        .pop   (w_pop),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    // Sticky flag for any strobe that found the buffer full
    always_ff @(posedge clock) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (lcd_write && w_full) begin
            r_overflow <= 1'b1;
        end
    end

    // Sequencer: one shared down-counter times power-up, EN pulse and post-pulse wait
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_PWRUP;
            r_cnt       <= 20'(PWRUP_WAIT - 1);
            r_init_idx  <= 2'd0;
            r_init_done <= 1'b0;
            r_data      <= 8'h00;
            r_rs        <= 1'b0;
            r_en        <= 1'b0;
        end else begin
            case (r_state)
                ST_PWRUP: begin
                    if (r_cnt == 20'd0) r_state <= ST_INIT;
                    else                r_cnt   <= r_cnt - 20'd1;
                end
                ST_INIT: begin
                    r_data  <= init_cmd(r_init_idx);
                    r_rs    <= 1'b0;
                    r_state <= ST_SETUP;
                end
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_data  <= w_head[7:0];
                        r_rs    <= ~w_head[8];
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_en    <= 1'b1;
                    r_cnt   <= 20'(EN_CYC - 1);
                    r_state <= ST_PULSE;
                end
                ST_PULSE: begin
                    if (r_cnt == 20'd0) begin
                        r_en    <= 1'b0;
                        r_cnt   <= w_wait_load;
                        r_state <= ST_WAIT;
                    end else begin
                        r_cnt <= r_cnt - 20'd1;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt != 20'd0) begin
                        r_cnt <= r_cnt - 20'd1;
                    end else if (r_init_done) begin
                        r_state <= ST_IDLE;
                    end else if (r_init_idx == 2'(INIT_LEN - 1)) begin
                        r_init_done <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_init_idx <= r_init_idx + 2'd1;
                        r_state    <= ST_INIT;
                    end
                end
                default: r_state <= ST_PWRUP;
            endcase
        end
    end

endmodule
